// File: rtl/intr_ctrl.sv
// intr_ctrl: four-source vectored interrupt controller.
// Edge-detected requests, fixed priority, one handler at a time.
module intr_ctrl #(
  parameter logic [9:0] VEC_BASE = 10'h3F0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq,
  input  logic       mask_we,
  input  logic [3:0] mask_in,
  input  logic       reti,
  output logic       s_int,
  output logic       push_int,
  output logic [9:0] vector,
  output logic [3:0] ack,
  output logic       in_service,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {
    IDLE,
    ENTER,
    SERVICE,
    EXIT
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] irq_q;
  logic [3:0] pend_q;
  logic [3:0] mask_q;
  logic [3:0] rise;
  logic [3:0] elig;
  logic [3:0] clr;
  logic [1:0] id_q;
  logic [1:0] sel;
  logic [9:0] vec_q;

  assign rise    = irq & ~irq_q;
  assign elig    = pend_q & mask_q;
  assign pending = pend_q;
  assign vector  = vec_q;

  // Lowest eligible index wins.
  always_comb begin
    sel = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (elig[i]) sel = 2'(i);
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    state_d    = state_q;
    s_int      = 1'b0;
    push_int   = 1'b0;
    ack        = 4'b0000;
    in_service = 1'b0;
    clr        = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (|elig) state_d = ENTER;
      end
      ENTER: begin
        s_int    = 1'b1;
        push_int = 1'b1;
        ack      = 4'b0001 << id_q;
        clr      = 4'b0001 << id_q;
        state_d  = SERVICE;
      end
      SERVICE: begin
        in_service = 1'b1;
        if (reti) state_d = EXIT;
      end
      EXIT: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accepted id and vector latch on entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      vec_q   <= VEC_BASE;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |elig) begin
        id_q  <= sel;
        vec_q <= VEC_BASE + {8'd0, sel};
      end
    end
  end

  // Request sampling, pending flags (new edge beats clear) and mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q  <= 4'b0000;
      pend_q <= 4'b0000;
      mask_q <= 4'b0000;
    end else begin
      irq_q  <= irq;
      pend_q <= (pend_q & ~clr) | rise;
      if (mask_we) mask_q <= mask_in;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: scenario tasks plus a scoreboard of expected
// interrupt entries checked whenever s_int is seen.
module tb_intr_ctrl;

  typedef struct {
    logic [9:0] vec;
    logic [3:0] ack;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       reti;
  logic       s_int;
  logic       push_int;
  logic [9:0] vector;
  logic [3:0] ack;
  logic       in_service;
  logic [3:0] pending;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   enters = 0;

  intr_ctrl #(.VEC_BASE(10'h3F0)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .mask_we   (mask_we),
    .mask_in   (mask_in),
    .reti      (reti),
    .s_int     (s_int),
    .push_int  (push_int),
    .vector    (vector),
    .ack       (ack),
    .in_service(in_service),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Entry monitor: every s_int cycle must match the next expected entry.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (s_int) begin
        enters++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL enter_unexpected ack=%b vector=%h wanted none",
                   ack, vector);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (ack !== e.ack || vector !== e.vec || push_int !== 1'b1) begin
            errors++;
            $display("FAIL enter ack=%b vec=%h push=%b wanted %b %h 1",
                     ack, vector, push_int, e.ack, e.vec);
          end
        end
      end else if (ack !== 4'b0000 || push_int !== 1'b0) begin
        errors++;
        $display("FAIL idle_strobes ack=%b push=%b wanted 0000 0",
                 ack, push_int);
      end
    end
  end

  task automatic set_mask(input logic [3:0] m);
    mask_we = 1'b1;
    mask_in = m;
    @(negedge clk);
    mask_we = 1'b0;
  endtask

  task automatic pulse(input logic [3:0] b);
    irq = irq | b;
    @(negedge clk);
    irq = irq & ~b;
  endtask

  task automatic expect_enter(input int id);
    exp_t e;
    e.vec = 10'h3F0 + 10'(id);
    e.ack = 4'b0001 << id;
    sb.push_back(e);
  endtask

  task automatic wait_service(input string name);
    int n;
    n = 0;
    while (in_service !== 1'b1 && n < 12) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_service !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout in_service=%b wanted 1", name, in_service);
    end
  endtask

  task automatic do_reti(input string name);
    reti = 1'b1;
    @(negedge clk);
    reti = 1'b0;
    checks++;
    if (in_service !== 1'b0 || s_int !== 1'b0) begin
      errors++;
      $display("FAIL %s_exit in_service=%b s_int=%b wanted 0 0",
               name, in_service, s_int);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    irq     = 4'b0000;
    mask_we = 1'b0;
    mask_in = 4'b0000;
    reti    = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (s_int !== 1'b0 || push_int !== 1'b0 || ack !== 4'b0000 ||
        in_service !== 1'b0 || pending !== 4'b0000 ||
        vector !== 10'h3F0) begin
      errors++;
      $display("FAIL reset_state s=%b p=%b a=%b is=%b pd=%b v=%h",
               s_int, push_int, ack, in_service, pending, vector);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    set_mask(4'b0001);
    expect_enter(0);
    pulse(4'b0001);
    wait_service("single");
    repeat (3) @(negedge clk);
    checks++;
    if (in_service !== 1'b1 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_hold in_service=%b pending=%b wanted 1 0000",
               in_service, pending);
    end
    do_reti("single");
    repeat (2) @(negedge clk);
  endtask

  task automatic test_priority();
    set_mask(4'b1111);
    expect_enter(1);
    expect_enter(3);
    pulse(4'b1010);
    wait_service("prio1");
    checks++;
    if (pending !== 4'b1000) begin
      errors++;
      $display("FAIL prio_pending got=%b wanted 1000", pending);
    end
    do_reti("prio1");
    wait_service("prio3");
    do_reti("prio3");
    repeat (2) @(negedge clk);
  endtask

  task automatic test_masked();
    int e0;
    set_mask(4'b0000);
    e0 = enters;
    pulse(4'b0100);
    repeat (3) @(negedge clk);
    checks++;
    if (pending !== 4'b0100 || enters != e0) begin
      errors++;
      $display("FAIL masked_hold pending=%b enters=%0d wanted 0100 %0d",
               pending, enters, e0);
    end
    expect_enter(2);
    set_mask(4'b0100);
    wait_service("masked");
    do_reti("masked");
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_nesting();
    int e0;
    set_mask(4'b0001);
    expect_enter(0);
    pulse(4'b0001);
    wait_service("nest");
    e0 = enters;
    pulse(4'b0001);
    repeat (10) @(negedge clk);
    checks++;
    if (enters != e0 || pending !== 4'b0001 || in_service !== 1'b1) begin
      errors++;
      $display("FAIL nest_hold enters=%0d pd=%b is=%b wanted %0d 0001 1",
               enters, pending, in_service, e0);
    end
    expect_enter(0);
    do_reti("nest");
    wait_service("nest2");
    do_reti("nest2");
    repeat (2) @(negedge clk);
  endtask

  task automatic test_held();
    int e0;
    set_mask(4'b0010);
    e0 = enters;
    expect_enter(1);
    irq = 4'b0010;
    wait_service("held");
    do_reti("held");
    repeat (14) @(negedge clk);
    checks++;
    if (enters != e0 + 1 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL held_once enters=%0d pending=%b wanted %0d 0000",
               enters - e0, pending, 1);
    end
    irq = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int e0;
    set_mask(4'b0100);
    expect_enter(2);
    pulse(4'b0100);
    wait_service("rstmid");
    pulse(4'b0010);
    #2;
    reset = 1'b0;
    irq   = 4'b1000;
    #1;
    checks++;
    if (in_service !== 1'b0 || pending !== 4'b0000 || s_int !== 1'b0 ||
        ack !== 4'b0000) begin
      errors++;
      $display("FAIL rstmid_async is=%b pd=%b s=%b a=%b wanted 0",
               in_service, pending, s_int, ack);
    end
    @(negedge clk);
    reset = 1'b1;
    e0 = enters;
    repeat (5) @(negedge clk);
    checks++;
    if (enters != e0 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid_release enters=%0d pending=%b wanted %0d 1000",
               enters, pending, e0);
    end
    set_mask(4'b0100);
    repeat (3) @(negedge clk);
    checks++;
    if (enters != e0 || in_service !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_nofire enters=%0d is=%b wanted %0d 0",
               enters, in_service, e0);
    end
    expect_enter(2);
    pulse(4'b0100);
    wait_service("rstmid2");
    do_reti("rstmid2");
    irq = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_masked();
    test_no_nesting();
    test_held();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got=%0d wanted 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
INTR_CTRL -- requirements
Module: intr_ctrl

Interface
REQ-001 SHALL have parameter VEC_BASE, default 10'h3F0, program-memory address of interrupt 0 jump slot.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port irq  input  4  interrupt request lines, synchronous to clk, index 0 highest priority.
REQ-005 SHALL have port mask_we  input  1  write enable for the mask register.
REQ-006 SHALL have port mask_in  input  4  new mask value, bit i=1 enables source i.
REQ-007 SHALL have port reti  input  1  one-cycle return-from-interrupt strobe decoded by the control unit.
REQ-008 SHALL have port s_int  output  1  selects vector as next PC.
REQ-009 SHALL have port push_int  output  1  pushes current PC onto the return stack.
REQ-010 SHALL have port vector  output  10  jump target for the accepted interrupt.
REQ-011 SHALL have port ack  output  4  one-hot acknowledge pulse to the accepted source.
REQ-012 SHALL have port in_service  output  1  high while a handler is running.
REQ-013 SHALL have port pending  output  4  current pending flags.

Function
REQ-014 SHALL register irq each cycle; rising edge on bit i = irq[i]=1 with previous sample 0.
REQ-015 SHALL set pending[i] on the clock edge at which the rising edge on irq[i] is detected; a held-high level SHALL NOT set it again.
REQ-016 SHALL clear pending[i] at the end of the ENTER cycle for accepted source i; a new edge on i in that cycle SHALL win (pending[i] stays 1).
REQ-017 SHALL compute eligible = pending & mask; masked pending bits SHALL be retained, not discarded.
REQ-018 SHALL implement states IDLE, ENTER, SERVICE, EXIT.
REQ-019 IDLE: if eligible != 0, SHALL latch id = lowest set index of eligible and move to ENTER; else stay.
REQ-020 ENTER: exactly one cycle; s_int=1, push_int=1, ack[id]=1, vector=VEC_BASE+id (10-bit, wraps modulo 1024); next SERVICE.
REQ-021 SERVICE: in_service=1; new requests only accumulate in pending (no nesting); reti=1 moves to EXIT.
REQ-022 EXIT: exactly one cycle, in_service=0, no entry allowed; next IDLE, guaranteeing one main-program instruction between handlers.
REQ-023 s_int, push_int, ack SHALL be 0 in every state except ENTER; vector SHALL hold its last value outside ENTER.
REQ-024 reti in IDLE, ENTER or EXIT SHALL be ignored.
REQ-025 mask_we=1 SHALL load mask_in on the next edge in any state; new mask affects only selections from the following cycle on.
REQ-026 Latency: edge sampled at edge N -> pending at N -> ENTER active during cycle after N (two edges min from irq rise to s_int).

Reset
REQ-027 reset=0 SHALL immediately force state IDLE, mask=0, pending=0, irq sample register=0, s_int=0, push_int=0, ack=0, in_service=0, vector=VEC_BASE.
REQ-028 Reset asserted mid-ENTER or mid-SERVICE SHALL abort the service with no further ack/push.
REQ-029 An irq line already high at reset release SHALL count as one rising edge.

Verification
REQ-030 mask=4'b0001, pulse irq[0] -> one ENTER cycle: s_int=1, push_int=1, ack=4'b0001, vector=10'h3F0; then in_service=1 until reti.
REQ-031 mask=4'b1111, irq[3] and irq[1] rise same cycle -> ENTER for id 1 (vector 10'h3F1); after reti, EXIT, then ENTER for id 3 (vector 10'h3F3).
REQ-032 mask=0, pulse irq[2] -> pending=4'b0100, no s_int; write mask=4'b0100 -> ENTER id 2 follows.
REQ-033 In SERVICE, pulse irq[0] and hold reti=0 for 10 cycles -> no ENTER, pending[0]=1; reti -> EXIT one cycle -> ENTER id 0.
REQ-034 irq[1] held high 20 cycles -> exactly one ack pulse on ack[1].
REQ-035 reset=0 during SERVICE -> in_service=0, pending=0, mask=0 asynchronously; no ack after release until new edge and mask write.
